// File: rtl/div_rs.sv
// rtl/div_rs.sv - four-entry collapsing reservation station for integer divide/remainder micro-ops
module div_rs #(
    parameter int DEPTH   = 4,
    parameter int ROB_LEN = 16,
    localparam int ROB_W  = $clog2(ROB_LEN),
    localparam int OCC_W  = $clog2(DEPTH) + 1,
    localparam int SEL_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [2:0]         disp_funct3,
    input  logic [ROB_W-1:0]   disp_rob_idx,
    input  logic [6:0]         disp_rd,
    input  logic [6:0]         disp_rs1_tag,
    input  logic [6:0]         disp_rs2_tag,
    input  logic               disp_rs1_rdy,
    input  logic               disp_rs2_rdy,
    input  logic [31:0]        disp_rs1_data,
    input  logic [31:0]        disp_rs2_data,
    input  logic               cdb_valid,
    input  logic [6:0]         cdb_rd,
    input  logic [31:0]        cdb_data,
    input  logic               mispredict,
    input  logic [ROB_LEN-1:0] flush_mask,
    input  logic               div_ready,
    output logic               iss_valid,
    output logic [2:0]         iss_funct3,
    output logic [ROB_W-1:0]   iss_rob_idx,
    output logic [6:0]         iss_rd,
    output logic [31:0]        iss_rs1_data,
    output logic [31:0]        iss_rs2_data,
    output logic [OCC_W-1:0]   occupancy
);

    typedef struct packed {
        logic             valid;
        logic [2:0]       funct3;
        logic [ROB_W-1:0] rob_idx;
        logic [6:0]       rd;
        logic [6:0]       tag1;
        logic             rdy1;
        logic [31:0]      data1;
        logic [6:0]       tag2;
        logic             rdy2;
        logic [31:0]      data2;
    } entry_t;

    entry_t           ent [DEPTH];
    entry_t           nxt [DEPTH];
    entry_t           woken;
    entry_t           din;
    logic [SEL_W-1:0] sel;
    logic             issue_fire;
    logic             keep;
    int               slot;

    // Entries stay packed from slot 0, so the valid count is also the first free slot.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(ent[i].valid);
        end
        disp_ready = occupancy < OCC_W'(DEPTH);
    end

    always_comb begin
        iss_valid = 1'b0;
        sel       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!iss_valid && ent[i].valid && ent[i].rdy1 && ent[i].rdy2 &&
                !(mispredict && flush_mask[ent[i].rob_idx])) begin
                iss_valid = 1'b1;
                sel       = SEL_W'(i);
            end
        end
        iss_funct3   = iss_valid ? ent[sel].funct3  : '0;
        iss_rob_idx  = iss_valid ? ent[sel].rob_idx : '0;
        iss_rd       = iss_valid ? ent[sel].rd      : '0;
        iss_rs1_data = iss_valid ? ent[sel].data1   : '0;
        iss_rs2_data = iss_valid ? ent[sel].data2   : '0;
        issue_fire   = iss_valid && div_ready;
    end

    // Dispatching op, with a CDB broadcast in the same cycle folded in.
    always_comb begin
        din         = '0;
        din.valid   = 1'b1;
        din.funct3  = disp_funct3;
        din.rob_idx = disp_rob_idx;
        din.rd      = disp_rd;
        din.tag1    = disp_rs1_tag;
        din.tag2    = disp_rs2_tag;
        din.rdy1    = disp_rs1_rdy || (cdb_valid && cdb_rd == disp_rs1_tag);
        din.rdy2    = disp_rs2_rdy || (cdb_valid && cdb_rd == disp_rs2_tag);
        din.data1   = disp_rs1_rdy ? disp_rs1_data : cdb_data;
        din.data2   = disp_rs2_rdy ? disp_rs2_data : cdb_data;
    end

    // Remove issued/flushed entries, compact survivors in order, then append the dispatch.
    always_comb begin
        woken = '0;
        keep  = 1'b0;
        slot  = 0;
        for (int j = 0; j < DEPTH; j++) begin
            nxt[j] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            woken = ent[i];
            if (cdb_valid && !woken.rdy1 && woken.tag1 == cdb_rd) begin
                woken.rdy1  = 1'b1;
                woken.data1 = cdb_data;
            end
            if (cdb_valid && !woken.rdy2 && woken.tag2 == cdb_rd) begin
                woken.rdy2  = 1'b1;
                woken.data2 = cdb_data;
            end
            keep = ent[i].valid && !(issue_fire && sel == SEL_W'(i)) &&
                   !(mispredict && flush_mask[ent[i].rob_idx]);
            if (keep) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == slot) nxt[j] = woken;
                end
                slot = slot + 1;
            end
        end
        if (disp_valid && disp_ready && !(mispredict && flush_mask[disp_rob_idx])) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == slot) nxt[j] = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_div_rs.sv
// tb/tb_div_rs.sv - directed and randomized checks of div_rs against a queue-based reference
module tb_div_rs;
    localparam int DEPTH   = 4;
    localparam int ROB_LEN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_valid, disp_ready;
    logic [2:0]  disp_funct3;
    logic [3:0]  disp_rob_idx;
    logic [6:0]  disp_rd, disp_rs1_tag, disp_rs2_tag;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0] disp_rs1_data, disp_rs2_data;
    logic        cdb_valid;
    logic [6:0]  cdb_rd;
    logic [31:0] cdb_data;
    logic        mispredict;
    logic [15:0] flush_mask;
    logic        div_ready;
    logic        iss_valid;
    logic [2:0]  iss_funct3;
    logic [3:0]  iss_rob_idx;
    logic [6:0]  iss_rd;
    logic [31:0] iss_rs1_data, iss_rs2_data;
    logic [2:0]  occupancy;

    div_rs #(.DEPTH(DEPTH), .ROB_LEN(ROB_LEN)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_funct3(disp_funct3), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
        .mispredict(mispredict), .flush_mask(flush_mask), .div_ready(div_ready),
        .iss_valid(iss_valid), .iss_funct3(iss_funct3), .iss_rob_idx(iss_rob_idx),
        .iss_rd(iss_rd), .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [2:0]  f;
        bit [3:0]  rob;
        bit [6:0]  rd;
        bit [6:0]  t1, t2;
        bit        r1, r2;
        bit [31:0] d1, d2;
    } op_t;

    op_t q[$];
    bit  exp_valid;
    int  exp_sel;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0; cdb_valid = 1'b0; mispredict = 1'b0; flush_mask = '0;
    endtask

    task automatic disp(input logic [2:0] f, input logic [3:0] rob, input logic [6:0] rd,
                        input logic [6:0] t1, input logic r1, input logic [31:0] d1,
                        input logic [6:0] t2, input logic r2, input logic [31:0] d2);
        disp_valid = 1'b1; disp_funct3 = f; disp_rob_idx = rob; disp_rd = rd;
        disp_rs1_tag = t1; disp_rs1_rdy = r1; disp_rs1_data = d1;
        disp_rs2_tag = t2; disp_rs2_rdy = r2; disp_rs2_data = d2;
    endtask

    // Oldest ready, unkilled op is the expected issue candidate.
    task automatic sample();
        @(negedge clk);
        exp_valid = 1'b0;
        exp_sel   = 0;
        foreach (q[i]) begin
            if (!exp_valid && q[i].r1 && q[i].r2 && !(mispredict && flush_mask[q[i].rob])) begin
                exp_valid = 1'b1;
                exp_sel   = i;
            end
        end
        chk("disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("iss_valid", 32'(iss_valid), 32'(exp_valid));
        chk("iss_funct3", 32'(iss_funct3), exp_valid ? 32'(q[exp_sel].f) : 32'd0);
        chk("iss_rob_idx", 32'(iss_rob_idx), exp_valid ? 32'(q[exp_sel].rob) : 32'd0);
        chk("iss_rd", 32'(iss_rd), exp_valid ? 32'(q[exp_sel].rd) : 32'd0);
        chk("iss_rs1_data", iss_rs1_data, exp_valid ? q[exp_sel].d1 : 32'd0);
        chk("iss_rs2_data", iss_rs2_data, exp_valid ? q[exp_sel].d2 : 32'd0);
    endtask

    task automatic tick();
        op_t nq[$];
        op_t e;
        bit  fired;
        fired = exp_valid && div_ready;
        foreach (q[i]) begin
            e = q[i];
            if (cdb_valid && !e.r1 && e.t1 == cdb_rd) begin e.r1 = 1; e.d1 = cdb_data; end
            if (cdb_valid && !e.r2 && e.t2 == cdb_rd) begin e.r2 = 1; e.d2 = cdb_data; end
            if (fired && i == exp_sel) continue;
            if (mispredict && flush_mask[e.rob]) continue;
            nq.push_back(e);
        end
        if (disp_valid && q.size() < DEPTH && !(mispredict && flush_mask[disp_rob_idx])) begin
            e.f = disp_funct3; e.rob = disp_rob_idx; e.rd = disp_rd;
            e.t1 = disp_rs1_tag; e.t2 = disp_rs2_tag;
            e.r1 = disp_rs1_rdy || (cdb_valid && cdb_rd == disp_rs1_tag);
            e.r2 = disp_rs2_rdy || (cdb_valid && cdb_rd == disp_rs2_tag);
            e.d1 = disp_rs1_rdy ? disp_rs1_data : cdb_data;
            e.d2 = disp_rs2_rdy ? disp_rs2_data : cdb_data;
            nq.push_back(e);
        end
        @(posedge clk);
        #1;
        q = nq;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    initial begin
        idle();
        div_ready = 1'b0;
        disp(3'd0, 4'd0, 7'd0, 7'd0, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0);
        disp_valid = 1'b0;
        cdb_rd = '0; cdb_data = '0;
        #12;
        chk("reset_disp_ready", 32'(disp_ready), 32'd1);
        chk("reset_iss_valid", 32'(iss_valid), 32'd0);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back ready ops
        div_ready = 1'b1;
        disp(3'b100, 4'd0, 7'd10, 7'd1, 1'b1, 32'd100, 7'd2, 1'b1, 32'd7);
        step();
        disp(3'b111, 4'd1, 7'd11, 7'd3, 1'b1, 32'd9, 7'd4, 1'b1, 32'd4);
        sample();
        chk("b2b_div_f3", 32'(iss_funct3), 32'd4);
        chk("b2b_div_rs1", iss_rs1_data, 32'd100);
        chk("b2b_div_rs2", iss_rs2_data, 32'd7);
        tick();
        idle();
        sample();
        chk("b2b_remu_f3", 32'(iss_funct3), 32'd7);
        chk("b2b_remu_rs1", iss_rs1_data, 32'd9);
        chk("b2b_remu_rs2", iss_rs2_data, 32'd4);
        tick();
        sample();
        chk("b2b_occ_zero", 32'(occupancy), 32'd0);
        tick();

        // Out-of-order readiness
        disp(3'b100, 4'd2, 7'd20, 7'd12, 1'b0, 32'd0, 7'd30, 1'b1, 32'd5);
        step();
        disp(3'b101, 4'd3, 7'd21, 7'd31, 1'b1, 32'd50, 7'd32, 1'b1, 32'd6);
        step();
        idle();
        cdb_valid = 1'b1; cdb_rd = 7'd12; cdb_data = 32'h8000_0000;
        sample();
        chk("ooo_b_first", 32'(iss_rob_idx), 32'd3);
        tick();
        idle();
        sample();
        chk("ooo_a_valid", 32'(iss_valid), 32'd1);
        chk("ooo_a_rob", 32'(iss_rob_idx), 32'd2);
        chk("ooo_a_rs1", iss_rs1_data, 32'h8000_0000);
        tick();
        step();

        // Dispatch-cycle bypass
        disp(3'b110, 4'd4, 7'd22, 7'd40, 1'b1, 32'd77, 7'd5, 1'b0, 32'd0);
        cdb_valid = 1'b1; cdb_rd = 7'd5; cdb_data = 32'd3;
        step();
        idle();
        sample();
        chk("bypass_valid", 32'(iss_valid), 32'd1);
        chk("bypass_rs2", iss_rs2_data, 32'd3);
        tick();
        step();

        // Full and stall
        div_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(3'(4 + k), 4'(8 + k), 7'(50 + k), 7'd60, 1'b1, 32'(1000 + k), 7'd61, 1'b1, 32'(k + 1));
            step();
        end
        disp(3'b100, 4'd12, 7'd55, 7'd60, 1'b1, 32'd1, 7'd61, 1'b1, 32'd1);
        sample();
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_occupancy", 32'(occupancy), 32'd4);
        chk("full_head", 32'(iss_rob_idx), 32'd8);
        tick();
        idle();
        div_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("drain_order", 32'(iss_rob_idx), 32'(8 + k));
            tick();
        end
        sample();
        chk("drain_empty", 32'(occupancy), 32'd0);
        tick();

        // Flush with simultaneous killed dispatch
        div_ready = 1'b0;
        for (int k = 2; k < 5; k++) begin
            disp(3'b100, 4'(k), 7'(k), 7'd70, 1'b1, 32'(k), 7'd71, 1'b1, 32'(k));
            step();
        end
        disp(3'b100, 4'd5, 7'd5, 7'd70, 1'b1, 32'd5, 7'd71, 1'b1, 32'd5);
        mispredict = 1'b1;
        flush_mask = 16'b0000_0000_0011_1000;
        step();
        idle();
        sample();
        chk("flush_occupancy", 32'(occupancy), 32'd1);
        chk("flush_survivor", 32'(iss_rob_idx), 32'd2);
        tick();
        div_ready = 1'b1;
        step();
        step();

        // Asynchronous reset during activity
        div_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(3'b101, 4'(k), 7'(k), 7'd80, 1'b1, 32'(k), 7'd81, 1'b1, 32'(k));
            step();
        end
        idle();
        sample();
        chk("pre_reset_valid", 32'(iss_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("async_rst_occupancy", 32'(occupancy), 32'd0);
        chk("async_rst_disp_ready", 32'(disp_ready), 32'd1);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic
        repeat (400) begin
            disp(3'($urandom_range(4, 7)), 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
                 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
            disp_valid = 1'($urandom_range(0, 1));
            cdb_valid  = 1'($urandom_range(0, 1));
            cdb_rd     = 7'($urandom_range(0, 7));
            cdb_data   = $urandom;
            mispredict = ($urandom_range(0, 7) == 0);
            flush_mask = 16'($urandom);
            div_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
